// File: rtl/room_sequencer_if.sv
// Bundle between room_sequencer and its neighbours: VGA timing and player position in,
// room coordinate, warp command and blanking out.
interface room_sequencer_if;
    logic       VBlank;
    logic [9:0] playerX;
    logic [8:0] playerY;
    logic       has_key;
    logic [3:0] mapX;
    logic [3:0] mapY;
    logic       warp_valid;
    logic [9:0] warp_x;
    logic [8:0] warp_y;
    logic       room_blank;
    logic       busy;

    modport master (
        output VBlank, playerX, playerY, has_key,
        input  mapX, mapY, warp_valid, warp_x, warp_y, room_blank, busy
    );

    modport slave (
        input  VBlank, playerX, playerY, has_key,
        output mapX, mapY, warp_valid, warp_x, warp_y, room_blank, busy
    );
endinterface

// File: rtl/room_sequencer.sv
// Room sequencer: once per frame checks the player against the screen edges and moves to
// the neighbouring room. Optional macro GATE_LOCK_EN locks the (1,3)->(1,2) castle gate.
module room_sequencer #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int EDGE         = 4,
    parameter int WARP_INSET   = 8,
    parameter int BLANK_FRAMES = 2,
    parameter int START_X      = 3,
    parameter int START_Y      = 4
) (
    input  logic           clk_vga,
    input  logic           reset,
    room_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_LOOKUP = 3'd2,
        S_COMMIT = 3'd3,
        S_BLANK  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        D_NONE   = 3'd0,
        D_TOP    = 3'd1,
        D_BOTTOM = 3'd2,
        D_LEFT   = 3'd3,
        D_RIGHT  = 3'd4
    } dir_t;

    localparam logic [8:0] Y_TOP_LIM    = 9'(EDGE);
    localparam logic [8:0] Y_BOT_LIM    = 9'(V_RES - 1 - EDGE);
    localparam logic [9:0] X_LEFT_LIM   = 10'(EDGE);
    localparam logic [9:0] X_RIGHT_LIM  = 10'(H_RES - 1 - EDGE);
    localparam logic [8:0] WARP_Y_TOP   = 9'(V_RES - 1 - WARP_INSET);
    localparam logic [8:0] WARP_Y_BOT   = 9'(WARP_INSET);
    localparam logic [9:0] WARP_X_LEFT  = 10'(H_RES - 1 - WARP_INSET);
    localparam logic [9:0] WARP_X_RIGHT = 10'(WARP_INSET);
    localparam logic [3:0] FRAMES_INIT  = 4'(BLANK_FRAMES);

    // Rooms that actually exist on the map; anything else behaves as a wall.
    function automatic logic in_room_set(input logic [3:0] x, input logic [3:0] y);
        case ({x, y})
            8'h34, 8'h35, 8'h36, 8'h46, 8'h47, 8'h26, 8'h16,
            8'h24, 8'h25, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11: in_room_set = 1'b1;
            default:                                         in_room_set = 1'b0;
        endcase
    endfunction

    state_t     r_state;
    logic       r_vblank_d;
    logic [3:0] r_map_x;
    logic [3:0] r_map_y;
    logic       r_warp_valid;
    logic [9:0] r_warp_x;
    logic [8:0] r_warp_y;
    logic       r_room_blank;
    logic [3:0] r_frames;

    dir_t       r_dir;
    logic [9:0] r_px;
    logic [8:0] r_py;
    logic [3:0] r_tgt_x;
    logic [3:0] r_tgt_y;

    state_t     w_state_nxt;
    logic [3:0] w_map_x_nxt;
    logic [3:0] w_map_y_nxt;
    logic       w_warp_valid_nxt;
    logic [9:0] w_warp_x_nxt;
    logic [8:0] w_warp_y_nxt;
    logic       w_blank_nxt;
    logic [3:0] w_frames_nxt;

    logic       w_vs_rise;
    dir_t       w_dir;
    logic [4:0] w_tx;
    logic [4:0] w_ty;
    logic       w_gate_ok;
    logic       w_tgt_ok;

    assign w_vs_rise = bus.VBlank & ~r_vblank_d;

    always_comb begin
        w_dir = D_NONE;
        if (bus.playerY < Y_TOP_LIM)
            w_dir = D_TOP;
        else if (bus.playerY > Y_BOT_LIM)
            w_dir = D_BOTTOM;
        else if (bus.playerX < X_LEFT_LIM)
            w_dir = D_LEFT;
        else if (bus.playerX > X_RIGHT_LIM)
            w_dir = D_RIGHT;
    end

    // Bit 4 of the target flags a step past 0 or 15; there is no wrap-around.
    always_comb begin
        w_tx = {1'b0, r_map_x};
        w_ty = {1'b0, r_map_y};
        case (r_dir)
            D_TOP:    w_ty = {1'b0, r_map_y} + 5'd1;
            D_BOTTOM: w_ty = {1'b0, r_map_y} - 5'd1;
            D_LEFT:   w_tx = {1'b0, r_map_x} - 5'd1;
            D_RIGHT:  w_tx = {1'b0, r_map_x} + 5'd1;
            default:  ;
        endcase
    end

`ifdef GATE_LOCK_EN
    assign w_gate_ok = bus.has_key ||
                       !((r_map_x == 4'd1) && (r_map_y == 4'd3) &&
                         (w_tx == 5'd1) && (w_ty == 5'd2));
`else
    logic w_unused_key;
    assign w_unused_key = bus.has_key;
    assign w_gate_ok    = 1'b1;
`endif

    assign w_tgt_ok = ~w_tx[4] & ~w_ty[4] & in_room_set(w_tx[3:0], w_ty[3:0]) & w_gate_ok;

    always_comb begin
        w_state_nxt      = r_state;
        w_map_x_nxt      = r_map_x;
        w_map_y_nxt      = r_map_y;
        w_warp_valid_nxt = 1'b0;
        w_warp_x_nxt     = r_warp_x;
        w_warp_y_nxt     = r_warp_y;
        w_blank_nxt      = r_room_blank;
        w_frames_nxt     = r_frames;
        case (r_state)
            S_IDLE: begin
                if (w_vs_rise)
                    w_state_nxt = S_CHECK;
            end
            S_CHECK: begin
                w_state_nxt = (w_dir == D_NONE) ? S_IDLE : S_LOOKUP;
            end
            S_LOOKUP: begin
                w_state_nxt = w_tgt_ok ? S_COMMIT : S_IDLE;
            end
            S_COMMIT: begin
                w_map_x_nxt      = r_tgt_x;
                w_map_y_nxt      = r_tgt_y;
                w_warp_valid_nxt = 1'b1;
                w_blank_nxt      = 1'b1;
                w_frames_nxt     = FRAMES_INIT;
                w_state_nxt      = S_BLANK;
                case (r_dir)
                    D_TOP: begin
                        w_warp_x_nxt = r_px;
                        w_warp_y_nxt = WARP_Y_TOP;
                    end
                    D_BOTTOM: begin
                        w_warp_x_nxt = r_px;
                        w_warp_y_nxt = WARP_Y_BOT;
                    end
                    D_LEFT: begin
                        w_warp_x_nxt = WARP_X_LEFT;
                        w_warp_y_nxt = r_py;
                    end
                    default: begin
                        w_warp_x_nxt = WARP_X_RIGHT;
                        w_warp_y_nxt = r_py;
                    end
                endcase
            end
            S_BLANK: begin
                // The frame edge that ends blanking is consumed, not evaluated.
                if (w_vs_rise) begin
                    w_frames_nxt = r_frames - 4'd1;
                    if (r_frames <= 4'd1) begin
                        w_blank_nxt = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_vga or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_vblank_d   <= 1'b0;
            r_map_x      <= 4'(START_X);
            r_map_y      <= 4'(START_Y);
            r_warp_valid <= 1'b0;
            r_warp_x     <= '0;
            r_warp_y     <= '0;
            r_room_blank <= 1'b0;
            r_frames     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_vblank_d   <= bus.VBlank;
            r_map_x      <= w_map_x_nxt;
            r_map_y      <= w_map_y_nxt;
            r_warp_valid <= w_warp_valid_nxt;
            r_warp_x     <= w_warp_x_nxt;
            r_warp_y     <= w_warp_y_nxt;
            r_room_blank <= w_blank_nxt;
            r_frames     <= w_frames_nxt;
        end
    end

    // Position/direction snapshot and target are pure data; every use is gated by state.
    always_ff @(posedge clk_vga) begin
        if (r_state == S_CHECK) begin
            r_px  <= bus.playerX;
            r_py  <= bus.playerY;
            r_dir <= w_dir;
        end
        if (r_state == S_LOOKUP) begin
            r_tgt_x <= w_tx[3:0];
            r_tgt_y <= w_ty[3:0];
        end
    end

    assign bus.mapX       = r_map_x;
    assign bus.mapY       = r_map_y;
    assign bus.warp_valid = r_warp_valid;
    assign bus.warp_x     = r_warp_x;
    assign bus.warp_y     = r_warp_y;
    assign bus.room_blank = r_room_blank;
    assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_room_sequencer.sv
// Bench for room_sequencer: vector table, directed corner sequences and a randomized
// walk checked against a frame-level model of the room map.
module tb_room_sequencer;

    localparam int H_RES        = 640;
    localparam int V_RES        = 480;
    localparam int EDGE         = 4;
    localparam int WARP_INSET   = 8;
    localparam int BLANK_FRAMES = 2;

    logic clk_vga = 1'b0;
    logic reset;

    room_sequencer_if bus();

    room_sequencer dut (
        .clk_vga (clk_vga),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_vga = ~clk_vga;

    int checks = 0;
    int errors = 0;

    // Per-frame observations.
    int f_wcnt, f_widx, f_cidx, f_wx, f_wy;

    // Frame-level model state.
    int m_x, m_y, m_blank;
    int rx[14] = '{3, 3, 3, 4, 4, 2, 1, 2, 2, 1, 1, 1, 1, 1};
    int ry[14] = '{4, 5, 6, 6, 7, 6, 6, 4, 5, 5, 4, 3, 2, 1};

    typedef struct {
        int px, py, key;
        int mv, ex, ey, wx, wy, blk;
    } vec_t;
    vec_t tbl[18];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.VBlank  = 1'b0;
        bus.playerX = '0;
        bus.playerY = '0;
        bus.has_key = 1'b0;
        @(negedge clk_vga);
        reset = 1'b0;
        repeat (3) @(negedge clk_vga);
        reset = 1'b1;
        m_x = 3; m_y = 4; m_blank = 0;
    endtask

    // One frame: VBlank high for 'hold' cycles, then low for 4.
    task automatic run_frame(input int px, input int py, input int key, input int hold);
        int mx0, my0;
        @(negedge clk_vga);
        bus.playerX = 10'(px);
        bus.playerY = 9'(py);
        bus.has_key = key[0];
        bus.VBlank  = 1'b1;
        mx0 = int'(bus.mapX);
        my0 = int'(bus.mapY);
        f_wcnt = 0; f_widx = -1; f_cidx = -1; f_wx = 0; f_wy = 0;
        for (int j = 0; j < hold; j++) begin
            @(negedge clk_vga);
            if (bus.warp_valid === 1'b1) begin
                f_wcnt++;
                if (f_widx < 0) f_widx = j;
                f_wx = int'(bus.warp_x);
                f_wy = int'(bus.warp_y);
            end
            if (f_cidx < 0 && (int'(bus.mapX) != mx0 || int'(bus.mapY) != my0))
                f_cidx = j;
        end
        bus.VBlank = 1'b0;
        repeat (4) @(negedge clk_vga);
    endtask

    task automatic check_frame(input string tag, input int mv, input int ex, input int ey,
                               input int wx, input int wy, input int blk);
        chk({tag, " mapX"}, int'(bus.mapX), ex);
        chk({tag, " mapY"}, int'(bus.mapY), ey);
        chk({tag, " room_blank"}, int'(bus.room_blank), blk);
        chk({tag, " busy"}, int'(bus.busy), blk);
        chk({tag, " warp_count"}, f_wcnt, mv);
        if (mv != 0) begin
            chk({tag, " warp_cycle"}, f_widx, 3);
            chk({tag, " map_change_cycle"}, f_cidx, 3);
            chk({tag, " warp_x"}, f_wx, wx);
            chk({tag, " warp_y"}, f_wy, wy);
        end else begin
            chk({tag, " map_change_cycle"}, f_cidx, -1);
        end
    endtask

    function automatic bit in_set(input int x, input int y);
        foreach (rx[i])
            if (rx[i] == x && ry[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_frame(input int px, input int py, input int key,
                                        output int moved, output int wx, output int wy);
        int dx, dy, tx, ty;
        bit ok;
        moved = 0; wx = 0; wy = 0; dx = 0; dy = 0;
        if (m_blank > 0) begin
            m_blank--;
            return;
        end
        if (py < EDGE) begin
            dy = 1; wx = px; wy = V_RES - 1 - WARP_INSET;
        end else if (py > V_RES - 1 - EDGE) begin
            dy = -1; wx = px; wy = WARP_INSET;
        end else if (px < EDGE) begin
            dx = -1; wx = H_RES - 1 - WARP_INSET; wy = py;
        end else if (px > H_RES - 1 - EDGE) begin
            dx = 1; wx = WARP_INSET; wy = py;
        end else begin
            return;
        end
        tx = m_x + dx;
        ty = m_y + dy;
        ok = (tx >= 0) && (tx <= 15) && (ty >= 0) && (ty <= 15) && in_set(tx, ty);
`ifdef GATE_LOCK_EN
        if (m_x == 1 && m_y == 3 && tx == 1 && ty == 2 && key == 0) ok = 1'b0;
`endif
        if (ok) begin
            m_x = tx; m_y = ty; m_blank = BLANK_FRAMES; moved = 1;
        end
    endfunction

    task automatic mframe(input string tag, input int px, input int py, input int key);
        int mv, wx, wy;
        model_frame(px, py, key, mv, wx, wy);
        run_frame(px, py, key, 10);
        check_frame(tag, mv, m_x, m_y, wx, wy, (m_blank > 0) ? 1 : 0);
    endtask

    function automatic int rand_coord(input int lo_max, input int hi_min, input int hi_max);
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, lo_max));
            1:       return int'($urandom_range(hi_min, hi_max));
            default: return int'($urandom_range(lo_max + 1, hi_min - 1));
        endcase
    endfunction

    initial begin
        tbl = '{
            '{300,   2, 0, 1, 3, 5, 300, 471, 1},
            '{300,   2, 0, 0, 3, 5,   0,   0, 1},
            '{300,   2, 0, 0, 3, 5,   0,   0, 0},
            '{300, 240, 0, 0, 3, 5,   0,   0, 0},
            '{300,   1, 0, 1, 3, 6, 300, 471, 1},
            '{300, 240, 0, 0, 3, 6,   0,   0, 1},
            '{300, 240, 0, 0, 3, 6,   0,   0, 0},
            '{637, 100, 0, 1, 4, 6,   8, 100, 1},
            '{637, 100, 0, 0, 4, 6,   0,   0, 1},
            '{637, 100, 0, 0, 4, 6,   0,   0, 0},
            '{637, 100, 0, 0, 4, 6,   0,   0, 0},
            '{ 50, 478, 0, 0, 4, 6,   0,   0, 0},
            '{  2, 200, 0, 1, 3, 6, 631, 200, 1},
            '{320, 240, 0, 0, 3, 6,   0,   0, 1},
            '{320, 240, 0, 0, 3, 6,   0,   0, 0},
            '{320, 477, 0, 1, 3, 5, 320,   8, 1},
            '{320, 240, 0, 0, 3, 5,   0,   0, 1},
            '{320, 240, 0, 0, 3, 5,   0,   0, 0}
        };

        reset       = 1'b0;
        bus.VBlank  = 1'b0;
        bus.playerX = '0;
        bus.playerY = '0;
        bus.has_key = 1'b0;
        repeat (3) @(negedge clk_vga);
        chk("rst mapX", int'(bus.mapX), 3);
        chk("rst mapY", int'(bus.mapY), 4);
        chk("rst room_blank", int'(bus.room_blank), 0);
        chk("rst warp_valid", int'(bus.warp_valid), 0);
        chk("rst warp_x", int'(bus.warp_x), 0);
        chk("rst warp_y", int'(bus.warp_y), 0);
        chk("rst busy", int'(bus.busy), 0);
        reset = 1'b1;
        @(negedge clk_vga);
        chk("post_rst busy", int'(bus.busy), 0);

        foreach (tbl[i]) begin
            run_frame(tbl[i].px, tbl[i].py, tbl[i].key, 10);
            check_frame($sformatf("tbl%0d", i), tbl[i].mv, tbl[i].ex, tbl[i].ey,
                        tbl[i].wx, tbl[i].wy, tbl[i].blk);
        end

        // Corner: top beats left.
        do_reset();
        run_frame(1, 1, 0, 10);
        check_frame("corner", 1, 3, 5, 1, 471, 1);

        // Reset in the middle of blanking takes effect without a clock edge.
        @(negedge clk_vga);
        #2;
        reset = 1'b0;
        #1;
        chk("midblank_rst room_blank", int'(bus.room_blank), 0);
        chk("midblank_rst mapX", int'(bus.mapX), 3);
        chk("midblank_rst mapY", int'(bus.mapY), 4);
        chk("midblank_rst busy", int'(bus.busy), 0);
        chk("midblank_rst warp_valid", int'(bus.warp_valid), 0);
        repeat (2) @(negedge clk_vga);
        reset = 1'b1;
        run_frame(300, 2, 0, 10);
        check_frame("after_rst", 1, 3, 5, 300, 471, 1);

        // A long VBlank is one frame edge: blanking must not advance twice.
        run_frame(300, 240, 0, 40);
        check_frame("long_vblank1", 0, 3, 5, 0, 0, 1);
        run_frame(300, 240, 0, 40);
        check_frame("long_vblank2", 0, 3, 5, 0, 0, 0);

        // Walk to the castle gate room (1,3) and try the gate with and without the key.
        do_reset();
        mframe("gate_a", 1, 200, 0);
        mframe("gate_b", 300, 240, 0);
        mframe("gate_c", 300, 240, 0);
        mframe("gate_d", 1, 200, 0);
        mframe("gate_e", 300, 240, 0);
        mframe("gate_f", 300, 240, 0);
        mframe("gate_g", 300, 478, 0);
        mframe("gate_h", 300, 240, 0);
        mframe("gate_i", 300, 240, 0);
        mframe("gate_nokey", 300, 478, 0);
        mframe("gate_j", 300, 240, 0);
        mframe("gate_k", 300, 240, 0);
        mframe("gate_key", 300, 478, 1);

        // Randomized walk.
        do_reset();
        for (int n = 0; n < 80; n++) begin
            int px, py, key;
            px  = rand_coord(5, 634, 700);
            py  = rand_coord(5, 474, 511);
            key = int'($urandom_range(0, 1));
            mframe($sformatf("rnd%0d", n), px, py, key);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
